// File: rtl/shift_reg_feeder_pkg.sv
// ============================================================================
// Module  : shift_reg_feeder_pkg
// Purpose : Shared mode, direction and state encodings for the serial feeder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_reg_feeder_pkg;

    // Mode codes understood by the downstream universal shift register
    localparam logic [1:0] SEL_CLR   = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

endpackage

`default_nettype wire

// File: rtl/shift_word_buf.sv
// ============================================================================
// Module  : shift_word_buf
// Purpose : One-entry valid/ready holding buffer with synchronous flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_word_buf #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    input  logic         flush_i
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         w_accept;

    // Ready depends on occupancy only, never on the writer's valid
    assign wr_ready_o = ~full_q;
    assign w_accept   = wr_valid_i & ~full_q;
    assign rd_valid_o = full_q;
    assign rd_data_o  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (w_accept) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_reg_feeder.sv
// ============================================================================
// Module  : shift_reg_feeder
// Purpose : Serialises buffered parallel words onto a universal shift register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_feeder
    import shift_reg_feeder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_dir_i,
    input  logic             abort_i,
    output logic             din_o,
    output logic [1:0]       sel_o,
    output logic             word_done_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] words_sent_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             buf_valid;
    logic             buf_rd;
    logic [WIDTH:0]   buf_data;
    logic [IDX_W-1:0] bit_sel;

    shift_word_buf #(
        .W(WIDTH + 1)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (in_valid_i),
        .wr_ready_o (in_ready_o),
        .wr_data_i  ({in_dir_i, in_data_i}),
        .rd_i       (buf_rd),
        .rd_valid_o (buf_valid),
        .rd_data_o  (buf_data),
        .flush_i    (abort_i)
    );

    // The buffer is drained only in the states that can start a new word
    assign buf_rd = ~abort_i & buf_valid & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (abort_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_DONE) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (buf_valid) begin
                        word_d  = buf_data[WIDTH-1:0];
                        dir_d   = buf_data[WIDTH];
                        idx_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            dir_q   <= DIR_LEFT;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Left mode sends MSB first, right mode LSB first
    assign bit_sel = (dir_q == DIR_RIGHT) ? idx_q : (IDX_LAST - idx_q);

    assign din_o        = (state_q == ST_SHIFT) & word_q[bit_sel];
    assign sel_o        = (state_q != ST_SHIFT) ? SEL_CLR :
                          (dir_q == DIR_LEFT)   ? SEL_LEFT : SEL_RIGHT;
    assign word_done_o  = (state_q == ST_DONE);
    assign busy_o       = (state_q == ST_SHIFT) | (state_q == ST_DONE);
    assign words_sent_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_feeder.sv
// ============================================================================
// Module  : tb_shift_reg_feeder
// Purpose : Self-checking bench for shift_reg_feeder with a downstream model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_dir = 1'b0;
    logic       abort = 1'b0;

    logic       in_ready, din, word_done, busy;
    logic [1:0] sel;
    logic [7:0] words_sent;
    logic       in_ready2, din2, word_done2, busy2;
    logic [1:0] sel2;
    logic [1:0] words_sent2;

    int vectors = 0;
    int miscompares = 0;

    // Downstream register model and completed-word log
    logic [3:0] sr;
    logic [3:0] done_val[$];
    int         done_cyc[$];
    int         cyc = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    shift_reg_feeder #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_dir_i(in_dir), .abort_i(abort), .din_o(din),
        .sel_o(sel), .word_done_o(word_done), .busy_o(busy), .words_sent_o(words_sent)
    );

    shift_reg_feeder #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .in_data_i(in_data), .in_dir_i(in_dir), .abort_i(abort), .din_o(din2),
        .sel_o(sel2), .word_done_o(word_done2), .busy_o(busy2), .words_sent_o(words_sent2)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= 4'd0;
        end else begin
            cyc <= cyc + 1;
            if (word_done) begin
                done_val.push_back(sr);
                done_cyc.push_back(cyc);
            end
            case (sel)
                2'b01:   sr <= {sr[2:0], din};
                2'b10:   sr <= {din, sr[3:1]};
                default: sr <= 4'd0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        done_val.delete();
        done_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    // Holds valid until the handshake completes; returns just after the accept edge
    task automatic send_word(input logic [3:0] data, input logic dir);
        bit ok = 1'b0;
        in_data = data;
        in_dir = dir;
        in_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_handshake: in_ready never rose for word %b", data);
        end else begin
            exp_q.push_back(data);
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_val.size() < n && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (done_val.size() < n) begin
            miscompares++;
            $display("FAIL wait_done: saw %0d word_done, required %0d", done_val.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        vectors++;
        if ({in_ready, din, sel, word_done, busy, words_sent} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b din=%b sel=%b done=%b busy=%b cnt=%0d, required 1 0 00 0 0 0",
                     in_ready, din, sel, word_done, busy, words_sent);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic run_directed(input logic [3:0] data, input logic dir, input string name);
        logic [1:0] exp_sel;
        logic       exp_bit;
        int         start_cnt;
        start_cnt = int'(words_sent);
        exp_sel = dir ? 2'b10 : 2'b01;
        send_word(data, dir);
        vectors++;
        if (sel !== 2'b00 || in_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_accept_cycle: sel=%b rdy=%b busy=%b, required 00 0 0", name, sel, in_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_bit = dir ? data[i] : data[3 - i];
            vectors++;
            if (sel !== exp_sel || din !== exp_bit) begin
                miscompares++;
                $display("FAIL %s_shift%0d: sel=%b din=%b, required %b %b", name, i, sel, din, exp_sel, exp_bit);
            end
        end
        tick();
        vectors++;
        if (word_done !== 1'b1 || sel !== 2'b00 || busy !== 1'b1 || sr !== data) begin
            miscompares++;
            $display("FAIL %s_done: done=%b sel=%b busy=%b d_out=%b, required 1 00 1 %b",
                     name, word_done, sel, busy, sr, data);
        end
        tick();
        vectors++;
        if (word_done !== 1'b0 || words_sent !== 8'(start_cnt + 1)) begin
            miscompares++;
            $display("FAIL %s_count: done=%b words_sent=%0d, required 0 %0d", name, word_done, words_sent, start_cnt + 1);
        end
    endtask

    task automatic test_left();
        run_directed(4'b1011, 1'b0, "left");
    endtask

    task automatic test_right();
        run_directed(4'b1011, 1'b1, "right");
    endtask

    task automatic test_back_to_back();
        clear_logs();
        send_word(4'b0101, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_ready_drop: in_ready=%b, required 0", in_ready);
        end
        send_word(4'b1100, 1'b1);
        wait_done(2, 30);
        if (done_val.size() >= 2) begin
            vectors++;
            if (done_val[0] !== 4'b0101 || done_val[1] !== 4'b1100) begin
                miscompares++;
                $display("FAIL b2b_words: got %b %b, required 0101 1100", done_val[0], done_val[1]);
            end
            vectors++;
            if (done_cyc[1] - done_cyc[0] != 5) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d cycles, required 5", done_cyc[1] - done_cyc[0]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_abort();
        logic [7:0] cnt0;
        clear_logs();
        cnt0 = words_sent;
        send_word(4'b1110, 1'b0);
        send_word(4'b0011, 1'b1);
        vectors++;
        if (sel !== 2'b01 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_setup: sel=%b rdy=%b, required 01 0", sel, in_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (sel !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b1 || word_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_next: sel=%b busy=%b rdy=%b done=%b, required 00 0 1 0", sel, busy, in_ready, word_done);
        end
        repeat (10) tick();
        vectors++;
        if (done_val.size() != 0 || words_sent !== cnt0) begin
            miscompares++;
            $display("FAIL abort_quiet: dones=%0d words_sent=%0d, required 0 %0d", done_val.size(), words_sent, cnt0);
        end
    endtask

    task automatic test_async_reset();
        clear_logs();
        send_word(4'b1001, 1'b0);
        send_word(4'b0110, 1'b0);
        tick();
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, din, sel, word_done, busy, words_sent} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL async_reset: rdy=%b din=%b sel=%b done=%b busy=%b cnt=%0d, required 1 0 00 0 0 0",
                     in_ready, din, sel, word_done, busy, words_sent);
        end
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        send_word(4'b0110, 1'b1);
        wait_done(1, 20);
        tick();
        vectors++;
        if (done_val.size() != 1 || done_val[0] !== 4'b0110 || words_sent !== 8'd1) begin
            miscompares++;
            $display("FAIL post_reset_word: dones=%0d cnt=%0d, required 1 word 0110 cnt 1", done_val.size(), words_sent);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_word(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            wait_done(k + 1, 20);
            tick();
            vectors++;
            if (words_sent2 !== 2'((k + 1) % 4) || words_sent !== 8'(k + 1)) begin
                miscompares++;
                $display("FAIL wrap_%0d: cnt2=%0d cnt8=%0d, required %0d %0d",
                         k, words_sent2, words_sent, (k + 1) % 4, k + 1);
            end
        end
    endtask

    task automatic test_random();
        int n = 30;
        do_reset();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                in_data = 4'($urandom);
                in_dir = 1'($urandom);
                tick();
            end
            send_word(4'($urandom), 1'($urandom));
            // Direction input wanders after the accept; words in flight must ignore it
            in_dir = 1'($urandom);
        end
        wait_done(n, 400);
        tick();
        for (int i = 0; i < n && i < done_val.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (done_val[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL random_word%0d: d_out=%b, required %b", i, done_val[i], exp_q[i]);
            end
            if (i > 0) begin
                vectors++;
                if (done_cyc[i] - done_cyc[i - 1] < 5) begin
                    miscompares++;
                    $display("FAIL random_spacing%0d: got %0d, required >= 5", i, done_cyc[i] - done_cyc[i - 1]);
                end
            end
        end
        vectors++;
        if (words_sent !== 8'(n) || words_sent2 !== 2'(n % 4)) begin
            miscompares++;
            $display("FAIL random_count: cnt8=%0d cnt2=%0d, required %0d %0d", words_sent, words_sent2, n, n % 4);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_right();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
